// File: rtl/clock_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Board clock is 100 MHz; half-period constants are in board-clock cycles.
package clock_div_pkg;

  localparam int unsigned CLK_FREQ_HZ   = 100000000;
  localparam int unsigned HALF_1HZ      = 50000000;
  localparam int unsigned HALF_10HZ     = 5000000;
  localparam int unsigned HALF_1KHZ     = 50000;
  localparam int unsigned CNT_W_DEFAULT = 29;

  // What a channel does on the coming clock edge, in priority order.
  typedef enum logic [1:0] {
    ActClear = 2'd0,  // phase realign, overrides everything
    ActHold  = 2'd1,  // global enable low
    ActWrap  = 2'd2,  // end of half-period: toggle and maybe apply staged value
    ActCount = 2'd3   // mid half-period
  } ch_act_e;

  // Half-period (in board-clock cycles) that yields the requested output frequency.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return CLK_FREQ_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/clock_divisor_ch.sv
// One divider channel: counter, active/staged half-period, output toggle and tick.
// Tick generation is built only when CLKDIV_TICK_EN is defined; otherwise tick is tied low.
module clock_divisor_ch
  import clock_div_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_HALF = HALF_1HZ
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             hp_wr,
  input  logic [CNT_W-1:0] hp_din,
  output logic             hp_pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DefHalf = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hp_q;
  logic [CNT_W-1:0] r_hp_nx;
  logic             r_pending;
  logic             r_clk;

  logic             w_wr_valid;
  logic             w_at_end;
  ch_act_e          w_act;

  // Decode this cycle's action; a zero half-period write is dropped.
  always_comb begin
    w_wr_valid = hp_wr && (hp_din != '0);
    w_at_end   = (r_cnt == (r_hp_q - CNT_W'(1)));
    if (sync_clear) begin
      w_act = ActClear;
    end else if (!en) begin
      w_act = ActHold;
    end else if (w_at_end) begin
      w_act = ActWrap;
    end else begin
      w_act = ActCount;
    end
  end

  // Counter, output toggle and active half-period; staged value applies only at a wrap or clear.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_hp_q <= DefHalf;
    end else begin
      unique case (w_act)
        ActClear: begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          // A write landing with the clear bypasses staging entirely.
          if (w_wr_valid) begin
            r_hp_q <= hp_din;
          end else if (r_pending) begin
            r_hp_q <= r_hp_nx;
          end
        end
        ActHold: begin
          r_cnt <= r_cnt;
        end
        ActWrap: begin
          r_cnt <= '0;
          r_clk <= ~r_clk;
          // Uses the value staged before this cycle; a same-cycle write waits a wrap.
          if (r_pending) begin
            r_hp_q <= r_hp_nx;
          end
        end
        ActCount: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Staging register and pending flag; a fresh write outranks the wrap that consumes the old one.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_hp_nx   <= DefHalf;
      r_pending <= 1'b0;
    end else begin
      if (w_wr_valid) begin
        r_hp_nx <= hp_din;
      end
      if (w_act == ActClear) begin
        r_pending <= 1'b0;
      end else if (w_wr_valid) begin
        r_pending <= 1'b1;
      end else if (w_act == ActWrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign hp_pending = r_pending;
  assign clk_out    = r_clk;

`ifdef CLKDIV_TICK_EN
  logic r_tick;

  // Tick fires on the edge where the registered output goes 0 -> 1.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (w_act == ActWrap) && !r_clk;
    end
  end

  assign tick = r_tick;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_divisor_multi.sv
// Multi-channel 50 %-duty clock divider for the coffee-maker timing path.
// Each channel has its own runtime-programmable half-period; en, sync_clear and hp_din
// are shared. Define CLKDIV_TICK_EN to generate the per-channel tick outputs.
module clock_divisor_multi
  import clock_div_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_HALF = HALF_1HZ
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clear,
  input  logic [NUM_CH-1:0] hp_wr,
  input  logic [CNT_W-1:0]  hp_din,
  output logic [NUM_CH-1:0] hp_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_divisor_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .en         (en),
      .sync_clear (sync_clear),
      .hp_wr      (hp_wr[g]),
      .hp_din     (hp_din),
      .hp_pending (hp_pending[g]),
      .clk_out    (clk_out[g]),
      .tick       (tick[g])
    );
  end

endmodule
